chip8_vga_scanout: RTL and testbench

- Display stage downstream of the CHIP-8 core. Reads the 32x64 monochrome frame buffer (32 rows of 64-bit words, vram) through a dedicated read port.
- Emits 640x480@60 VGA timing with each CHIP-8 pixel scaled 8x8, centred in the visible area.
- Also emits a once-per-frame strobe that the core's 60 Hz delay/sound timers use.

---
 rtl/chip8_vga_scanout.sv | 166 ++++++++++++++++
 tb/tb_chip8_vga_scanout.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_vga_scanout.sv
// CHIP-8 display scan-out: 640x480@60 VGA timing with the 64x32 monochrome
// frame buffer scaled SCALE x SCALE and placed at (H_OFFSET, V_OFFSET).
// One row word is fetched from vram during the horizontal blanking before
// each scan line and held in line_buf for the whole visible part of that line.
module chip8_vga_scanout #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned SCALE        = 8,
  parameter int unsigned H_OFFSET     = 64,
  parameter int unsigned V_OFFSET     = 112,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  FG_COLOR     = 8'hFF,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] vram_data_in,
  output logic [4:0]  vram_address_out,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [7:0]  vga_rgb,
  output logic        video_active,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // SCALE is a power of two, so pixel-to-cell mapping is a right shift
  localparam int unsigned SHIFT   = $clog2(SCALE);

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START    = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END      = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_IMG_START = HW'(H_OFFSET);
  localparam logic [HW-1:0] H_IMG_END   = HW'(H_OFFSET + 64 * SCALE);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START    = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END      = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_IMG_START = VW'(V_OFFSET);
  localparam logic [VW-1:0] V_IMG_END   = VW'(V_OFFSET + 32 * SCALE);
  localparam logic [1:0]    WAIT_LAST   = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_LATCH
  } fetch_state_t;

  fetch_state_t   state;
  logic [DW-1:0]  divider;
  logic [HW-1:0]  hcount;
  logic [VW-1:0]  vcount;
  logic [63:0]    line_buf;
  logic [1:0]     wait_cnt;

  logic           tick;
  logic           visible;
  logic           in_img;
  logic [HW-1:0]  h_rel;
  logic [5:0]     col;
  logic [VW-1:0]  v_next;
  logic [VW-1:0]  nv_rel;
  logic           nv_in_img;
  logic [4:0]     nv_row;

  // Pixel tick, region decode and next-line row selection
  always_comb begin
    tick      = (divider == DIV_LAST);
    visible   = (hcount < H_VIS_END) && (vcount < V_VIS_END);
    in_img    = (hcount >= H_IMG_START) && (hcount < H_IMG_END) &&
                (vcount >= V_IMG_START) && (vcount < V_IMG_END);
    h_rel     = hcount - H_IMG_START;
    col       = 6'(h_rel >> SHIFT);
    v_next    = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    nv_in_img = (v_next >= V_IMG_START) && (v_next < V_IMG_END);
    nv_rel    = v_next - V_IMG_START;
    nv_row    = 5'(nv_rel >> SHIFT);
  end

  // Clock divider, raster counters and registered VGA outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divider      <= '0;
      hcount       <= '0;
      vcount       <= '0;
      vga_hsync    <= 1'b1;
      vga_vsync    <= 1'b1;
      vga_rgb      <= '0;
      video_active <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        divider <= '0;
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
        vga_hsync    <= !((hcount >= HS_START) && (hcount < HS_END));
        vga_vsync    <= !((vcount >= VS_START) && (vcount < VS_END));
        video_active <= visible;
        if (!visible)
          vga_rgb <= '0;
        else if (in_img)
          vga_rgb <= line_buf[col] ? FG_COLOR : BG_COLOR;
        else
          vga_rgb <= BORDER_COLOR;
        frame_start  <= (hcount == H_LAST) && (vcount == V_LAST);
      end else begin
        divider <= divider + 1'b1;
      end
    end
  end

  // Row fetch during horizontal blanking; the line number cannot change
  // before ST_ADDR, so the row is recomputed there rather than stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      line_buf         <= '0;
      vram_address_out <= '0;
      wait_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && (hcount == H_VIS_END) && nv_in_img)
            state <= ST_ADDR;
        end
        ST_ADDR: begin
          vram_address_out <= nv_row;
          wait_cnt         <= '0;
          state            <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST)
            state <= ST_LATCH;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        ST_LATCH: begin
          line_buf <= vram_data_in;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Bench for chip8_vga_scanout with reduced raster timing so several whole
// frames fit in a short run. A behavioural raster model pushes the expected
// output vector for every clock into a scoreboard queue; each test pops it
// after the DUT edge and compares.
module tb_chip8_vga_scanout;

  localparam int CLK_DIV   = 2;
  localparam int H_VISIBLE = 136;
  localparam int H_FRONT   = 2;
  localparam int H_SYNC    = 4;
  localparam int H_BACK    = 2;
  localparam int V_VISIBLE = 68;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 2;
  localparam int SCALE     = 2;
  localparam int H_OFFSET  = 4;
  localparam int V_OFFSET  = 2;
  localparam int RL        = 2;
  localparam logic [7:0] FG     = 8'hFF;
  localparam logic [7:0] BG     = 8'h00;
  localparam logic [7:0] BORDER = 8'h03;

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;

  logic        clock;
  logic        reset;
  logic [63:0] vram_data_in;
  logic [4:0]  vram_address_out;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [7:0]  vga_rgb;
  logic        video_active;
  logic        frame_start;

  chip8_vga_scanout #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT),
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .V_VISIBLE(V_VISIBLE),
    .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .SCALE(SCALE),
    .H_OFFSET(H_OFFSET), .V_OFFSET(V_OFFSET), .READ_LATENCY(RL),
    .FG_COLOR(FG), .BG_COLOR(BG), .BORDER_COLOR(BORDER)
  ) dut (
    .clock(clock), .reset(reset), .vram_data_in(vram_data_in),
    .vram_address_out(vram_address_out), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_rgb(vga_rgb), .video_active(video_active),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous frame-buffer read port with RL clocks of latency
  logic [63:0] mem [32];
  logic [63:0] rd_p0, rd_p1;
  always @(posedge clock) begin
    rd_p0 <= mem[vram_address_out];
    rd_p1 <= rd_p0;
  end
  assign vram_data_in = rd_p1;

  int checks = 0;
  int failures = 0;

  logic [11:0] sb[$];
  int          m_div, m_h, m_v, m_addr, m_clk, m_ticks;
  logic [63:0] m_line;
  logic [11:0] m_held;
  logic        m_tick, m_eol;

  function automatic logic [11:0] decode(int h, int v, logic [63:0] line);
    logic hs, vs, act;
    logic [7:0] rgb;
    hs  = !(h >= H_VISIBLE + H_FRONT && h < H_VISIBLE + H_FRONT + H_SYNC);
    vs  = !(v >= V_VISIBLE + V_FRONT && v < V_VISIBLE + V_FRONT + V_SYNC);
    act = (h < H_VISIBLE) && (v < V_VISIBLE);
    if (!act)
      rgb = 8'h00;
    else if (h >= H_OFFSET && h < H_OFFSET + 64 * SCALE &&
             v >= V_OFFSET && v < V_OFFSET + 32 * SCALE)
      rgb = line[(h - H_OFFSET) / SCALE] ? FG : BG;
    else
      rgb = BORDER;
    return {hs, vs, act, 1'b0, rgb};
  endfunction

  task automatic reset_model();
    m_div = 0; m_h = 0; m_v = 0; m_addr = 0; m_clk = 0; m_ticks = 0;
    m_line = '0; m_held = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    m_tick = 1'b0; m_eol = 1'b0;
    sb.delete();
  endtask

  // One clock of the raster model; pushes the expected output vector
  task automatic step();
    logic [11:0] e;
    logic tk;
    int nv;
    tk = (m_div == CLK_DIV - 1);
    @(posedge clock);
    m_eol = 1'b0;
    if (tk) begin
      e = decode(m_h, m_v, m_line);
      if (m_h == H_TOTAL - 1 && m_v == V_TOTAL - 1) e[8] = 1'b1;
      if (m_h == H_VISIBLE) begin
        nv = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        if (nv >= V_OFFSET && nv < V_OFFSET + 32 * SCALE) begin
          m_addr = (nv - V_OFFSET) / SCALE;
          m_line = mem[m_addr];
        end
      end
      if (m_h == H_TOTAL - 1) begin
        m_h = 0; m_eol = 1'b1;
        m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_div = 0;
      m_ticks = m_ticks + 1;
    end else begin
      e = m_held;
      e[8] = 1'b0;
      m_div = m_div + 1;
    end
    m_held = e;
    m_tick = tk;
    m_clk = m_clk + 1;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (vga_hsync !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%b exp=1", vga_hsync); end
    checks++; if (vga_vsync !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%b exp=1", vga_vsync); end
    checks++; if (vga_rgb !== 8'h00) begin failures++; $display("FAIL rst_rgb got=%h exp=00", vga_rgb); end
    checks++; if (video_active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", video_active); end
    checks++; if (vram_address_out !== 5'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", vram_address_out); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
  endtask

  task automatic test_first_tick();
    logic [11:0] e;
    @(negedge clock);
    reset = 1'b1;
    reset_model();
    step();
    e = sb.pop_front();
    checks++; if (video_active !== 1'b0) begin failures++; $display("FAIL first_clk_active got=%b exp=0", video_active); end
    checks++; if ({vga_hsync, vga_vsync, video_active, frame_start, vga_rgb} !== e) begin
      failures++; $display("FAIL first_clk_vec got=%h exp=%h", {vga_hsync, vga_vsync, video_active, frame_start, vga_rgb}, e); end
    step();
    e = sb.pop_front();
    checks++; if (video_active !== 1'b1) begin failures++; $display("FAIL second_clk_active got=%b exp=1", video_active); end
    checks++; if (vga_rgb !== BORDER) begin failures++; $display("FAIL second_clk_rgb got=%h exp=%h", vga_rgb, BORDER); end
    checks++; if ({vga_hsync, vga_vsync, video_active, frame_start, vga_rgb} !== e) begin
      failures++; $display("FAIL second_clk_vec got=%h exp=%h", {vga_hsync, vga_vsync, video_active, frame_start, vga_rgb}, e); end
  endtask

  task automatic test_frame();
    logic [11:0] e;
    logic seen = 1'b0;
    int hs_fall = -1, hs_len = -1, vs_fall = -1, vs_len = -1, fg = 0, fs_clk = -1;
    for (int i = 0; i < FRAME_CLK + 100 && !seen; i++) begin
      step();
      e = sb.pop_front();
      checks++; if ({vga_hsync, vga_vsync, video_active, frame_start, vga_rgb} !== e) begin
        failures++;
        $display("FAIL frame_px clk=%0d got=%h exp=%h", m_clk, {vga_hsync, vga_vsync, video_active, frame_start, vga_rgb}, e);
      end
      if (m_tick) begin
        if (vga_rgb == FG) fg++;
        if (!vga_hsync && hs_fall < 0) hs_fall = m_ticks;
        if (vga_hsync && hs_fall >= 0 && hs_len < 0) hs_len = m_ticks - hs_fall;
        if (!vga_vsync && vs_fall < 0) vs_fall = m_ticks;
        if (vga_vsync && vs_fall >= 0 && vs_len < 0) vs_len = m_ticks - vs_fall;
      end
      if (m_eol) begin
        checks++; if (vram_address_out !== 5'(m_addr)) begin
          failures++; $display("FAIL fetch_addr line=%0d got=%0d exp=%0d", m_v, vram_address_out, m_addr); end
        if (m_v == V_OFFSET + 31 * SCALE || m_v == V_OFFSET + 31 * SCALE + 1) begin
          checks++; if (vram_address_out !== 5'd31) begin
            failures++; $display("FAIL row31_addr line=%0d got=%0d exp=31", m_v, vram_address_out); end
        end
      end
      if (frame_start === 1'b1) begin seen = 1'b1; fs_clk = m_clk; end
    end
    checks++; if (fs_clk != FRAME_CLK) begin failures++; $display("FAIL first_frame_start got=%0d exp=%0d", fs_clk, FRAME_CLK); end
    checks++; if (hs_fall != H_VISIBLE + H_FRONT + 1) begin failures++; $display("FAIL hsync_fall got=%0d exp=%0d", hs_fall, H_VISIBLE + H_FRONT + 1); end
    checks++; if (hs_len != H_SYNC) begin failures++; $display("FAIL hsync_len got=%0d exp=%0d", hs_len, H_SYNC); end
    checks++; if (vs_fall != (V_VISIBLE + V_FRONT) * H_TOTAL + 1) begin
      failures++; $display("FAIL vsync_fall got=%0d exp=%0d", vs_fall, (V_VISIBLE + V_FRONT) * H_TOTAL + 1); end
    checks++; if (vs_len != V_SYNC * H_TOTAL) begin failures++; $display("FAIL vsync_len got=%0d exp=%0d", vs_len, V_SYNC * H_TOTAL); end
    // row 0 and row 31 light one cell each, row 10 lights four; each cell is SCALE*SCALE pixels
    checks++; if (fg != 6 * SCALE * SCALE) begin failures++; $display("FAIL fg_pixels got=%0d exp=%0d", fg, 6 * SCALE * SCALE); end
  endtask

  task automatic test_vram_update();
    logic [11:0] e;
    logic seen = 1'b0, changed = 1'b0;
    int start = m_clk, pv, fg_old = 0, fg_new = 0, fs_gap = -1;
    for (int i = 0; i < FRAME_CLK + 100 && !seen; i++) begin
      pv = m_v;
      step();
      e = sb.pop_front();
      checks++; if ({vga_hsync, vga_vsync, video_active, frame_start, vga_rgb} !== e) begin
        failures++;
        $display("FAIL update_px clk=%0d got=%h exp=%h", m_clk, {vga_hsync, vga_vsync, video_active, frame_start, vga_rgb}, e);
      end
      if (m_tick && vga_rgb == FG) begin
        if (pv == V_OFFSET + 5 * SCALE) fg_old++;
        if (pv == V_OFFSET + 5 * SCALE + 1) fg_new++;
      end
      if (!changed && m_v == V_OFFSET + 5 * SCALE && m_h == 60) begin
        mem[5] = '1;
        changed = 1'b1;
      end
      if (frame_start === 1'b1) begin seen = 1'b1; fs_gap = m_clk - start; end
    end
    checks++; if (fg_old != 0) begin failures++; $display("FAIL midline_old got=%0d exp=0", fg_old); end
    checks++; if (fg_new != 64 * SCALE) begin failures++; $display("FAIL nextline_new got=%0d exp=%0d", fg_new, 64 * SCALE); end
    checks++; if (fs_gap != FRAME_CLK) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", fs_gap, FRAME_CLK); end
  endtask

  task automatic test_mid_reset();
    logic [11:0] e;
    logic seen = 1'b0, hit = 1'b0;
    int fs_clk = -1;
    for (int i = 0; i < FRAME_CLK && !hit; i++) begin
      step();
      void'(sb.pop_front());
      if (m_v == 5 && m_h == 100) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL mid_reset_reach got=0 exp=1"); end
    reset = 1'b0;
    #1;
    checks++; if ({vga_hsync, vga_vsync, video_active, frame_start, vga_rgb} !== 12'hC00) begin
      failures++; $display("FAIL mid_reset_outputs got=%h exp=c00", {vga_hsync, vga_vsync, video_active, frame_start, vga_rgb}); end
    checks++; if (vram_address_out !== 5'd0) begin failures++; $display("FAIL mid_reset_addr got=%0d exp=0", vram_address_out); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    reset_model();
    for (int i = 0; i < FRAME_CLK + 100 && !seen; i++) begin
      step();
      e = sb.pop_front();
      checks++; if ({vga_hsync, vga_vsync, video_active, frame_start, vga_rgb} !== e) begin
        failures++;
        $display("FAIL after_reset_px clk=%0d got=%h exp=%h", m_clk, {vga_hsync, vga_vsync, video_active, frame_start, vga_rgb}, e);
      end
      if (frame_start === 1'b1) begin seen = 1'b1; fs_clk = m_clk; end
    end
    checks++; if (fs_clk != FRAME_CLK) begin failures++; $display("FAIL after_reset_frame_start got=%0d exp=%0d", fs_clk, FRAME_CLK); end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = '0;
    mem[0]  = 64'h0000_0000_0000_0001;
    mem[10] = 64'h0000_0000_0000_00F0;
    mem[31] = 64'h8000_0000_0000_0000;
    reset_model();
    test_reset();
    test_first_tick();
    test_frame();
    test_vram_update();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
